// File: rtl/ec1_control_unit.sv
// ec1_control_unit: EC-1 sequencer FSM driving datapath strobes, with halt/state/retired-count debug taps
module ec1_control_unit #(
  parameter int ICNT_W  = 8,
  parameter int STATE_W = 3
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [2:0]         IR75,
  input  logic               Aneq0,
  input  logic               Enter,
  output logic               IRload,
  output logic               PCload,
  output logic               INmux,
  output logic               Aload,
  output logic               JNZmux,
  output logic               Halt,
  output logic [STATE_W-1:0] State,
  output logic [ICNT_W-1:0]  InstrCnt
);
  typedef enum logic [2:0] {FETCH, DECODE, INPUT, OUTPUT, DEC, JNZ, JMP, HALT} state_t;
  state_t state_q, state_d;
  logic [ICNT_W-1:0] cnt_q;
  logic retire;
  // next state; opcodes 001..101 map to INPUT..JMP in order, 11x are NOPs
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE:  state_d = IR75 == 3'b000 ? HALT : IR75[2:1] == 2'b11 ? FETCH : state_t'(IR75 + 3'd1);
      INPUT:   state_d = Enter ? FETCH : INPUT;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end
  assign retire = (state_q == INPUT && Enter) || state_q inside {OUTPUT, DEC, JNZ, JMP}
                  || (state_q == DECODE && IR75[2:1] == 2'b11);
  // strobes are suppressed during reset so an aborted instruction leaves the datapath untouched
  assign IRload   = !Reset && state_q == FETCH;
  assign PCload   = !Reset && (state_q == FETCH || state_q == JMP || (state_q == JNZ && Aneq0));
  assign INmux    = !Reset && state_q == INPUT;
  assign Aload    = !Reset && (state_q == DEC || (state_q == INPUT && Enter));
  assign JNZmux   = !Reset && (state_q == JNZ || state_q == JMP);
  assign Halt     = state_q == HALT;
  assign State    = STATE_W'(state_q);
  assign InstrCnt = cnt_q;
  // state register and saturating retired-instruction counter
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (retire && !(&cnt_q)) cnt_q <= cnt_q + ICNT_W'(1);
    end
  end
endmodule

// File: tb/tb_ec1_control_unit.sv
// tb_ec1_control_unit: instruction-level reference model with random and directed programs
module tb_ec1_control_unit;
  logic Clk = 0, Reset = 1, Aneq0 = 0, Enter = 0;
  logic [2:0] IR75 = 0;
  logic IRload, PCload, INmux, Aload, JNZmux, Halt;
  logic [2:0] State;
  logic [7:0] InstrCnt;
  logic s_ir, s_pc, s_in, s_a, s_j, s_h;
  logic [2:0] s_st;
  logic [1:0] cnt2;
  int total = 0, bad = 0, cnt = 0;

  ec1_control_unit dut (.Clk(Clk), .Reset(Reset), .IR75(IR75), .Aneq0(Aneq0), .Enter(Enter),
    .IRload(IRload), .PCload(PCload), .INmux(INmux), .Aload(Aload), .JNZmux(JNZmux),
    .Halt(Halt), .State(State), .InstrCnt(InstrCnt));
  ec1_control_unit #(.ICNT_W(2)) dut2 (.Clk(Clk), .Reset(Reset), .IR75(IR75), .Aneq0(Aneq0), .Enter(Enter),
    .IRload(s_ir), .PCload(s_pc), .INmux(s_in), .Aload(s_a), .JNZmux(s_j),
    .Halt(s_h), .State(s_st), .InstrCnt(cnt2));

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: drive at negedge, check settled outputs, let the next rising edge happen
  task automatic cyc(input logic rs, input logic [2:0] ir, input logic en, input logic an,
                     input logic full, input logic [2:0] est, input logic [4:0] exs, input string tag);
    @(negedge Clk);
    Reset = rs; IR75 = ir; Enter = en; Aneq0 = an;
    #1;
    chk({tag, "_strobes"}, 32'({IRload, PCload, INmux, Aload, JNZmux}), 32'(exs));
    if (full) begin
      chk({tag, "_state"}, 32'(State), 32'(est));
      chk({tag, "_halt"}, 32'(Halt), 32'(est == 3'd7));
      chk({tag, "_cnt"}, 32'(InstrCnt), 32'(cnt > 255 ? 255 : cnt));
      chk({tag, "_cnt2"}, 32'(cnt2), 32'(cnt > 3 ? 3 : cnt));
    end
  endtask

  task automatic rst(input int n);
    for (int i = 0; i < n; i++) cyc(1, 3'($urandom), 1'($urandom), 1'($urandom), 0, 0, 0, "reset");
    cnt = 0;
  endtask

  // expected trace of one whole instruction, built from its opcode
  task automatic instr(input logic [2:0] op, input int nlow, input logic an);
    cyc(0, 3'($urandom), 1'($urandom), an, 1, 0, 5'b11000, "fetch");
    cyc(0, op, 1'($urandom), an, 1, 1, 0, "decode");
    case (op)
      3'd0: for (int i = 0; i < 20; i++) cyc(0, 3'($urandom), 1'(i), 1'($urandom), 1, 7, 0, "halt");
      3'd1: begin
        for (int i = 0; i < nlow; i++) cyc(0, 3'($urandom), 0, an, 1, 2, 5'b00100, "input_wait");
        cyc(0, 3'($urandom), 1, an, 1, 2, 5'b00110, "input_load");
      end
      3'd2: cyc(0, 3'($urandom), 1'($urandom), an, 1, 3, 0, "output");
      3'd3: cyc(0, 3'($urandom), 1'($urandom), an, 1, 4, 5'b00010, "dec");
      3'd4: cyc(0, 3'($urandom), 1'($urandom), an, 1, 5, {1'b0, an, 3'b001}, "jnz");
      3'd5: cyc(0, 3'($urandom), 1'($urandom), an, 1, 6, 5'b01001, "jmp");
      default: ;
    endcase
    if (op != 3'd0) cnt++;
  endtask

  initial begin
    rst(3);
    instr(3, 0, 1);
    instr(1, 4, 0);
    instr(1, 0, 1);
    instr(4, 0, 1);
    instr(4, 0, 0);
    instr(2, 0, 1);
    instr(5, 0, 0);
    instr(6, 0, 1);
    instr(7, 0, 0);
    instr(0, 0, 1);
    rst(1);
    for (int i = 0; i < 5; i++) instr(3, 0, 1);
    cyc(0, 3'($urandom), 0, 0, 1, 0, 5'b11000, "mid_fetch");
    cyc(0, 3'd1, 0, 0, 1, 1, 0, "mid_decode");
    cyc(0, 3'($urandom), 0, 0, 1, 2, 5'b00100, "mid_wait");
    cyc(1, 3'($urandom), 0, 0, 0, 0, 0, "mid_reset");
    cyc(1, 3'($urandom), 1, 1, 0, 0, 0, "mid_reset_enter");
    cnt = 0;
    instr(3, 0, 0);
    for (int i = 0; i < 270; i++)
      instr(3'($urandom_range(7, 1)), int'($urandom_range(4, 0)), 1'($urandom));
    instr(0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
